quad_sqrt: RTL

QUAD_SQRT -- requirements
Module: quad_sqrt

---
 rtl/quad_pkg.sv | 7 +
 rtl/quad_sqrt_step.sv | 17 +
 rtl/quad_sqrt.sv | 85 ++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// quad_pkg: default widths and FSM state type shared by the quad_sqrt block.
package quad_pkg;
   localparam int IN_W_D   = 29;
   localparam int ROOT_W_D = 15;
   localparam int REM_W_D  = 16;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/quad_sqrt_step.sv
// quad_sqrt_step: one restoring square-root recurrence iteration (combinational).
module quad_sqrt_step #(
   parameter int ROOT_W = 15,
   parameter int REM_W  = 16
) (
   input  logic [REM_W:0]    rem,
   input  logic [ROOT_W-1:0] root,
   input  logic [1:0]        bits,
   output logic [REM_W:0]    rem_nxt,
   output logic              bit_nxt
);
   logic [REM_W+2:0] t, trial;
   assign t       = {rem, bits};
   assign trial   = (REM_W+3)'({root, 2'b01});
   assign bit_nxt = t >= trial;
   assign rem_nxt = (REM_W+1)'(bit_nxt ? t - trial : t);
endmodule

// File: rtl/quad_sqrt.sv
// quad_sqrt: sequential integer square root, one root bit per cycle, MSB first.
// Define QUAD_SQRT_ROUND_EN to round out_root to nearest; out_rem stays the floor remainder.
module quad_sqrt
   import quad_pkg::*;
#(
   parameter int IN_W   = IN_W_D,
   parameter int ROOT_W = ROOT_W_D,
   parameter int REM_W  = REM_W_D
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ROOT_W-1:0] out_root,
   output logic [REM_W-1:0]  out_rem
);
   localparam int CW = $clog2(ROOT_W + 1);
   state_t              state, state_nxt;
   logic [2*ROOT_W-1:0] opnd;
   logic [ROOT_W-1:0]   root, root_fin, root_out, out_root_q;
   logic [REM_W:0]      rem, rem_nxt;
   logic [REM_W-1:0]    out_rem_q;
   logic [CW-1:0]       cnt;
   logic                bit_nxt;

   quad_sqrt_step #(.ROOT_W(ROOT_W), .REM_W(REM_W)) u_step (
      .rem(rem), .root(root), .bits(opnd[2*ROOT_W-1 -: 2]),
      .rem_nxt(rem_nxt), .bit_nxt(bit_nxt)
   );

   assign root_fin = {root[ROOT_W-2:0], bit_nxt};
`ifdef QUAD_SQRT_ROUND_EN
   // round up when the floor remainder exceeds the floor root (x > r^2 + r)
   assign root_out = root_fin + ROOT_W'(rem_nxt > (REM_W+1)'(root_fin));
`else
   assign root_out = root_fin;
`endif

   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign out_root  = out_root_q;
   assign out_rem   = out_rem_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = in_valid ? CALC : IDLE;
         CALC:    state_nxt = cnt == '0 ? DONE : CALC;
         DONE:    state_nxt = out_ready ? IDLE : DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opnd       <= '0;
         root       <= '0;
         rem        <= '0;
         cnt        <= '0;
         out_root_q <= '0;
         out_rem_q  <= '0;
      end else if (state == IDLE && in_valid) begin
         opnd <= (2*ROOT_W)'(in_data);
         root <= '0;
         rem  <= '0;
         cnt  <= CW'(ROOT_W - 1);
      end else if (state == CALC) begin
         opnd <= opnd << 2;
         root <= root_fin;
         rem  <= rem_nxt;
         if (cnt != '0) cnt <= cnt - 1'b1;
         if (cnt == '0) begin
            out_root_q <= root_out;
            out_rem_q  <= rem_nxt[REM_W-1:0];
         end
      end
   end
endmodule
